// File: rtl/ad9122_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ad9122_spi_pkg
//  Purpose  : Shared types and constants for the AD9122 SPI master: FSM state
//             encoding, word layout, SCLK edge indices and counter-width helpers.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ad9122_spi_pkg;

    // Transaction phases, in the order a word walks through them.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Word layout: [15]=R/W (1=read), [14:8]=register address, [7:0]=data.
    localparam int WORD_BITS     = 16;
    localparam int RW_BIT        = 15;
    localparam int RD_BITS       = 8;
    // First SCLK rise (1-based) on which the device drives read data.
    localparam int RD_FIRST_EDGE = 9;

    // SCLK edges per word: 16 rises + 16 falls, numbered 0..31.
    localparam int EDGE_W = $clog2(2 * WORD_BITS);

    // Edge counter is even before a rise and odd before a fall.
    // Rise k (1-based) is edge 2*(k-1); fall k is edge 2*k-1.
    localparam logic [EDGE_W-1:0] RD_RISE_FIRST = EDGE_W'(2 * (RD_FIRST_EDGE - 1));
    // Fall after which the data byte begins; from here SDIO is forced low on reads.
    localparam logic [EDGE_W-1:0] RD_FALL_FIRST = EDGE_W'(2 * (RD_FIRST_EDGE - 1) - 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE     = EDGE_W'(2 * WORD_BITS - 1);

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : ad9122_spi_pkg
`default_nettype wire

// File: rtl/ad9122_spi_tick.sv
`default_nettype none
// ============================================================================
//  Module   : ad9122_spi_tick
//  Purpose  : SCLK timing generator. Divides clk_i by CLK_DIV while enabled and
//             emits one strobe per SCLK half-period, tagged as rise or fall, plus
//             the index (0..31) of the edge about to be produced.
//  Ports    : clk_i        system clock
//             rst_i        synchronous reset, active-high
//             en_i         count while high (SHIFT phase)
//             clr_i        restart divider and edge index (entry to SHIFT)
//             rise_tick_o  next clock edge should raise SCLK
//             fall_tick_o  next clock edge should lower SCLK
//             edge_cnt_o   index of the edge the current strobe produces
//  Revision : 1.0 - initial release
// ============================================================================
module ad9122_spi_tick
    import ad9122_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              clr_i,
    output logic              rise_tick_o,
    output logic              fall_tick_o,
    output logic [EDGE_W-1:0] edge_cnt_o
);

    localparam int              DIV_W    = cnt_w(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]  div_q,  div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic              tick;

    // Strobe on the last cycle of each half-period so the SCLK register
    // toggles exactly CLK_DIV cycles after the previous toggle (or after clear).
    assign tick = en_i && (div_q == DIV_LAST);

    always_comb begin
        div_d  = div_q;
        edge_d = edge_q;
        if (clr_i) begin
            div_d  = '0;
            edge_d = '0;
        end else if (en_i) begin
            if (tick) begin
                div_d  = '0;
                edge_d = edge_q + 1'b1;
            end else begin
                div_d  = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q  <= '0;
            edge_q <= '0;
        end else begin
            div_q  <= div_d;
            edge_q <= edge_d;
        end
    end

    assign rise_tick_o = tick && !edge_q[0];
    assign fall_tick_o = tick &&  edge_q[0];
    assign edge_cnt_o  = edge_q;

endmodule : ad9122_spi_tick
`default_nettype wire

// File: rtl/ad9122_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : ad9122_spi_master
//  Purpose  : Shifts one 16-bit config word per CONFIG_EN handshake MSB-first
//             onto the AD9122 4-wire SPI port and returns the read byte for
//             read words. Pulses config_end_o once CS_N is back high.
//  Ports    : clk_i          system clock
//             rst_i          synchronous reset, active-high
//             config_en_i    level request; word valid while high
//             config_data_i  config word, sampled on accept only
//             config_end_o   1-cycle pulse: word done, CS_N high
//             busy_o         high from accept until the CS gap has elapsed
//             rd_data_o      last read byte, held until the next read
//             rd_valid_o     1-cycle pulse with config_end_o on read words
//             spi_cs_n_o     chip select, active-low
//             spi_sclk_o     serial clock, idle low
//             spi_sdio_o     serial data to device
//             spi_sdo_i      serial data from device
//  Revision : 1.0 - initial release
// ============================================================================
module ad9122_spi_master
    import ad9122_spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,   // clk cycles per SCLK half-period (>=1)
    parameter int CS_SETUP = 2,   // CS_N fall to SCLK activity (>=1)
    parameter int CS_HOLD  = 2,   // last SCLK fall to CS_N rise (>=1)
    parameter int CS_GAP   = 4    // minimum CS_N high time between words (>=1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 config_en_i,
    input  logic [WORD_BITS-1:0] config_data_i,
    output logic                 config_end_o,
    output logic                 busy_o,
    output logic [RD_BITS-1:0]   rd_data_o,
    output logic                 rd_valid_o,
    output logic                 spi_cs_n_o,
    output logic                 spi_sclk_o,
    output logic                 spi_sdio_o,
    input  logic                 spi_sdo_i
);

    // One phase counter serves SETUP, HOLD and GAP; size it for the longest.
    localparam int PH_MAX = max_int(max_int(CS_SETUP - 1, CS_HOLD), CS_GAP - 1);
    localparam int PH_W   = cnt_w(PH_MAX);

    localparam logic [PH_W-1:0] PH_SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0] PH_HOLD_LAST  = PH_W'(CS_HOLD);
    localparam logic [PH_W-1:0] PH_GAP_LAST   = PH_W'(CS_GAP - 1);

    state_e                 state_q;
    logic                   armed_q;
    logic [PH_W-1:0]        ph_cnt_q;
    // Bits still to be sent after the current one; bit 15 goes out on accept.
    logic [WORD_BITS-2:0]   sh_q;
    logic                   rd_q;
    logic [RD_BITS-1:0]     rd_sr_q;

    logic                   cs_n_q;
    logic                   sclk_q;
    logic                   sdio_q;
    logic                   end_q;
    logic                   rd_valid_q;
    logic [RD_BITS-1:0]     rd_data_q;
    logic                   busy_q;

    logic                   setup_done;
    logic                   rise_tick;
    logic                   fall_tick;
    logic [EDGE_W-1:0]      edge_cnt;

    assign setup_done = (state_q == ST_SETUP) && (ph_cnt_q == PH_SETUP_LAST);

    // Divider restarts on the same edge that enters SHIFT, so the first
    // SCLK rise lands CLK_DIV cycles into the phase.
    ad9122_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (state_q == ST_SHIFT),
        .clr_i       (setup_done),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick),
        .edge_cnt_o  (edge_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b1;
            ph_cnt_q   <= '0;
            sh_q       <= '0;
            rd_q       <= 1'b0;
            rd_sr_q    <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            sdio_q     <= 1'b0;
            end_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            end_q      <= 1'b0;
            rd_valid_q <= 1'b0;

            // A request level that stays high across END must not replay the
            // word: the requester has to drop EN for a cycle to re-arm.
            if (!config_en_i) begin
                armed_q <= 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (config_en_i && armed_q) begin
                        armed_q  <= 1'b0;
                        sh_q     <= config_data_i[WORD_BITS-2:0];
                        rd_q     <= config_data_i[RW_BIT];
                        rd_sr_q  <= '0;
                        cs_n_q   <= 1'b0;
                        sdio_q   <= config_data_i[WORD_BITS-1];
                        busy_q   <= 1'b1;
                        ph_cnt_q <= '0;
                        state_q  <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (setup_done) begin
                        ph_cnt_q <= '0;
                        state_q  <= ST_SHIFT;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (rise_tick) begin
                        sclk_q <= 1'b1;
                        // Sample SDO on the same edge the device sees its rise;
                        // the device changes SDO after the preceding fall.
                        if (rd_q && (edge_cnt >= RD_RISE_FIRST)) begin
                            rd_sr_q <= {rd_sr_q[RD_BITS-2:0], spi_sdo_i};
                        end
                    end
                    if (fall_tick) begin
                        sclk_q <= 1'b0;
                        sh_q   <= {sh_q[WORD_BITS-3:0], 1'b0};
                        // During the data byte of a read the device owns the
                        // data phase, so keep our line quiet.
                        if (rd_q && (edge_cnt >= RD_FALL_FIRST)) begin
                            sdio_q <= 1'b0;
                        end else begin
                            sdio_q <= sh_q[WORD_BITS-2];
                        end
                        if (edge_cnt == LAST_EDGE) begin
                            ph_cnt_q <= '0;
                            state_q  <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (ph_cnt_q == PH_HOLD_LAST) begin
                        cs_n_q   <= 1'b1;
                        end_q    <= 1'b1;
                        if (rd_q) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= rd_sr_q;
                        end
                        ph_cnt_q <= '0;
                        state_q  <= ST_GAP;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (ph_cnt_q == PH_GAP_LAST) begin
                        busy_q   <= 1'b0;
                        ph_cnt_q <= '0;
                        state_q  <= ST_IDLE;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign config_end_o = end_q;
    assign busy_o       = busy_q;
    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign spi_cs_n_o   = cs_n_q;
    assign spi_sclk_o   = sclk_q;
    assign spi_sdio_o   = sdio_q;

endmodule : ad9122_spi_master
`default_nettype wire

// File: tb/tb_ad9122_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ad9122_spi_master
//  Purpose  : Scoreboard bench for ad9122_spi_master. Instance 0 uses default
//             timing, instance 1 the fastest timing (CLK_DIV=1, setup/hold=1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ad9122_spi_master;

    localparam int LAT0 = 1 + 2 + 32 * 4 + 2;   // 133
    localparam int LAT1 = 1 + 1 + 32 * 1 + 1;   // 35
    localparam int GAP0 = 4;
    localparam int GAP1 = 2;

    typedef struct {
        logic [15:0] pat;      // bits expected on SDIO at the 16 SCLK rises
        logic        rd;
        logic [7:0]  rd_byte;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en      [2];
    logic [15:0] data    [2];
    logic        sdo     [2];
    logic        end_o   [2];
    logic        busy    [2];
    logic [7:0]  rdd     [2];
    logic        rdv     [2];
    logic        cs_n    [2];
    logic        sclk    [2];
    logic        sdio    [2];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    exp_t        sb0[$];
    exp_t        sb1[$];

    // Monitor state, one slot per instance.
    logic        prev_cs   [2];
    logic        prev_sclk [2];
    logic        prev_end  [2];
    int          rise_n    [2];
    int          fall_n    [2];
    int          t_start   [2];
    int          t_rise    [2];
    bit          have_rise [2];
    logic [15:0] got       [2];
    logic [7:0]  last_rd   [2];
    logic [7:0]  sdo_byte  [2];
    int          frames    [2];
    int          ends      [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ad9122_spi_master #(
        .CLK_DIV (4), .CS_SETUP (2), .CS_HOLD (2), .CS_GAP (GAP0)
    ) dut0 (
        .clk_i (clk), .rst_i (rst), .config_en_i (en[0]), .config_data_i (data[0]),
        .config_end_o (end_o[0]), .busy_o (busy[0]), .rd_data_o (rdd[0]),
        .rd_valid_o (rdv[0]), .spi_cs_n_o (cs_n[0]), .spi_sclk_o (sclk[0]),
        .spi_sdio_o (sdio[0]), .spi_sdo_i (sdo[0])
    );

    ad9122_spi_master #(
        .CLK_DIV (1), .CS_SETUP (1), .CS_HOLD (1), .CS_GAP (GAP1)
    ) dut1 (
        .clk_i (clk), .rst_i (rst), .config_en_i (en[1]), .config_data_i (data[1]),
        .config_end_o (end_o[1]), .busy_o (busy[1]), .rd_data_o (rdd[1]),
        .rd_valid_o (rdv[1]), .spi_cs_n_o (cs_n[1]), .spi_sclk_o (sclk[1]),
        .spi_sdio_o (sdio[1]), .spi_sdo_i (sdo[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp_v, $time);
        end
    endtask

    // Frame monitor + device SDO model, sampled on the falling clock edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                prev_cs[k]   = 1'b1;
                prev_sclk[k] = 1'b0;
                prev_end[k]  = 1'b0;
                rise_n[k]    = 0;
                fall_n[k]    = 0;
                have_rise[k] = 1'b0;
                last_rd[k]   = 8'h00;
                sdo[k]       = 1'b0;
            end else begin
                if (prev_cs[k] && !cs_n[k]) begin
                    frames[k]++;
                    rise_n[k]  = 0;
                    fall_n[k]  = 0;
                    got[k]     = 16'h0000;
                    t_start[k] = cyc;
                    sdo[k]     = 1'b0;
                    if (have_rise[k])
                        check_eq($sformatf("d%0d_cs_gap_ok", k),
                                 32'((cyc - t_rise[k]) >= ((k == 0) ? GAP0 : GAP1)), 32'd1);
                end
                if (!prev_cs[k] && cs_n[k]) begin
                    t_rise[k]    = cyc;
                    have_rise[k] = 1'b1;
                end
                if (!prev_sclk[k] && sclk[k]) begin
                    rise_n[k]++;
                    got[k] = {got[k][14:0], sdio[k]};
                end
                if (prev_sclk[k] && !sclk[k]) begin
                    fall_n[k]++;
                    if (fall_n[k] >= 8 && fall_n[k] <= 15)
                        sdo[k] = sdo_byte[k][15 - fall_n[k]];
                    else
                        sdo[k] = 1'b0;
                end
                if (end_o[k]) begin
                    exp_t e;
                    ends[k]++;
                    check_eq($sformatf("d%0d_end_single", k), 32'(prev_end[k]), 32'd0);
                    if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
                        check_eq($sformatf("d%0d_unexpected_end", k), 32'd1, 32'd0);
                    end else begin
                        e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                        check_eq($sformatf("d%0d_latency", k), 32'(cyc - t_start[k]),
                                 32'((k == 0) ? LAT0 : LAT1));
                        check_eq($sformatf("d%0d_sdio_word", k), 32'(got[k]), 32'(e.pat));
                        check_eq($sformatf("d%0d_rise_count", k), 32'(rise_n[k]), 32'd16);
                        check_eq($sformatf("d%0d_cs_high_at_end", k), 32'(cs_n[k]), 32'd1);
                        check_eq($sformatf("d%0d_rd_valid", k), 32'(rdv[k]), 32'(e.rd));
                        if (e.rd) last_rd[k] = e.rd_byte;
                        check_eq($sformatf("d%0d_rd_data", k), 32'(rdd[k]), 32'(last_rd[k]));
                    end
                end else if (rdv[k]) begin
                    check_eq($sformatf("d%0d_rd_valid_without_end", k), 32'(rdv[k]), 32'd0);
                end
                prev_cs[k]   = cs_n[k];
                prev_sclk[k] = sclk[k];
                prev_end[k]  = end_o[k];
            end
        end
    end

    // Issue one word through the command-stage handshake and wait for END.
    task automatic send(input int k, input logic [15:0] w, input logic [7:0] b, input bit drop_en);
        exp_t e;
        int   e0;
        bool_wait: begin end
        e.pat     = w[15] ? {w[15:8], 8'h00} : w;
        e.rd      = w[15];
        e.rd_byte = b;
        if (k == 0) sb0.push_back(e); else sb1.push_back(e);
        sdo_byte[k] = b;
        e0 = ends[k];
        @(posedge clk); #1;
        en[k]   = 1'b1;
        data[k] = w;
        for (int i = 0; i < 50 && cs_n[k] !== 1'b0; i++) begin
            @(posedge clk); #1;
        end
        // Once accepted, the input word must no longer matter.
        data[k] = ~w;
        for (int i = 0; i < 1000 && ends[k] == e0; i++) begin
            @(posedge clk); #1;
        end
        if (ends[k] == e0)
            check_eq($sformatf("d%0d_end_timeout_%04h", k, w), 32'd0, 32'd1);
        if (drop_en) en[k] = 1'b0;
    endtask

    initial begin
        int f0;
        int e0;
        for (int k = 0; k < 2; k++) begin
            en[k] = 1'b0; data[k] = 16'h0000; sdo_byte[k] = 8'h00;
            frames[k] = 0; ends[k] = 0; got[k] = 16'h0000;
            t_start[k] = 0; t_rise[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cs_n",     32'(cs_n[0]),  32'd1);
        check_eq("rst_sclk",     32'(sclk[0]),  32'd0);
        check_eq("rst_sdio",     32'(sdio[0]),  32'd0);
        check_eq("rst_end",      32'(end_o[0]), 32'd0);
        check_eq("rst_rd_valid", 32'(rdv[0]),   32'd0);
        check_eq("rst_busy",     32'(busy[0]),  32'd0);
        check_eq("rst_rd_data",  32'(rdd[0]),   32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Write, then reads with device data on SDO.
        send(0, 16'h1048, 8'h00, 1'b1);
        send(0, 16'h9F00, 8'hA5, 1'b1);
        send(0, 16'h8A3C, 8'h5A, 1'b1);

        // Back-to-back handshake, EN dropped right after each END.
        send(0, 16'h0020, 8'h00, 1'b1);
        send(0, 16'h0000, 8'h00, 1'b1);
        send(0, 16'h1048, 8'h00, 1'b1);

        // EN held high after END must not restart; a 1-cycle drop re-arms.
        send(0, 16'h2211, 8'h00, 1'b0);
        f0 = frames[0];
        repeat (300) @(posedge clk);
        #1;
        check_eq("held_en_no_restart", 32'(frames[0] - f0), 32'd0);
        en[0] = 1'b0;
        send(0, 16'h3377, 8'h00, 1'b1);

        // Reset in the middle of a frame, around SCLK rise 7.
        e0 = ends[0];
        @(posedge clk); #1;
        en[0] = 1'b1; data[0] = 16'hFFFF;
        for (int i = 0; i < 50 && cs_n[0] !== 1'b0; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 400 && rise_n[0] < 7; i++) begin
            @(posedge clk); #1;
        end
        check_eq("rst_mid_reached_rise7", 32'(rise_n[0] >= 7), 32'd1);
        rst = 1'b1; en[0] = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_cs_n", 32'(cs_n[0]), 32'd1);
        check_eq("rst_mid_sclk", 32'(sclk[0]), 32'd0);
        check_eq("rst_mid_busy", 32'(busy[0]), 32'd0);
        rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check_eq("rst_mid_no_end", 32'(ends[0] - e0), 32'd0);
        send(0, 16'h1705, 8'h00, 1'b1);

        // Fastest timing instance.
        send(1, 16'h40FF, 8'h00, 1'b1);
        send(1, 16'h4503, 8'h00, 1'b1);

        repeat (20) @(posedge clk);
        #1;
        check_eq("sb0_drained", 32'(sb0.size()), 32'd0);
        check_eq("sb1_drained", 32'(sb1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ad9122_spi_master
`default_nettype wire
